// File: rtl/led_pwm_multi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_pwm_multi_pkg                                          |
// | Description : Shared mode encodings, ramp direction type and helpers for |
// |               the multi-channel LED PWM driver. The mode values match    |
// |               the software register map of the single-channel LED block. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package led_pwm_multi_pkg;

  // Values 5..7 are never stored; writes carrying them are rejected.
  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_PWM     = 3'd2,
    MODE_BLINK   = 3'd3,
    MODE_BREATHE = 3'd4
  } led_mode_e;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode <= 3'(MODE_BREATHE));
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_multi_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_pwm_multi_if                                           |
// | Description : Valid/ready configuration write port of led_pwm_multi.     |
// |   valid  master->slave  write request                                    |
// |   ready  slave->master  pending slot free                                |
// |   ch     master->slave  target channel                                   |
// |   mode   master->slave  channel mode (raw 3-bit, may be illegal)         |
// |   duty   master->slave  duty / brightness ceiling                        |
// |   err    slave->master  1-cycle pulse for a rejected write               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface led_pwm_multi_if #(
  parameter int NCH   = 8,
  parameter int PWM_W = 8
) ();

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              valid;
  logic              ready;
  logic [CH_W-1:0]   ch;
  logic [2:0]        mode;
  logic [PWM_W-1:0]  duty;
  logic              err;

  modport master (output valid, output ch, output mode, output duty,
                  input  ready, input  err);
  modport slave  (input  valid, input  ch, input  mode, input  duty,
                  output ready, output err);

endinterface

`default_nettype wire

// File: rtl/led_pwm_ch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_pwm_ch                                                 |
// | Description : One LED channel: mode/duty shadow registers updated on a   |
// |               period-boundary commit strobe, compare against the shared  |
// |               PWM counter, registered LED output.                        |
// |   clk, rst_n         clock, asynchronous active-low reset                 |
// |   commit             load new_mode/new_duty into the shadow registers     |
// |   new_mode/new_duty  committed configuration                              |
// |   pwm_cnt            shared PWM counter                                   |
// |   blink_ph           shared blink phase (1 = lit half)                    |
// |   ramp               shared breathe ramp                                  |
// |   led                registered LED drive                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module led_pwm_ch
  import led_pwm_multi_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  led_mode_e        new_mode,
  input  logic [PWM_W-1:0] new_duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             blink_ph,
  input  logic [PWM_W-1:0] ramp,
  output logic             led
);

  led_mode_e        r_mode;
  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] w_level;
  logic             w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_OFF;
      r_duty <= '0;
    end else if (commit) begin
      r_mode <= new_mode;
      r_duty <= new_duty;
    end
  end

  // Breathe brightness is the ramp, capped by the programmed duty.
  assign w_level = (r_duty < ramp) ? r_duty : ramp;

  always_comb begin
    w_next = 1'b0;
    case (r_mode)
      MODE_OFF:     w_next = 1'b0;
      MODE_ON:      w_next = 1'b1;
      MODE_PWM:     w_next = (pwm_cnt < r_duty);
      MODE_BLINK:   w_next = blink_ph & (pwm_cnt < r_duty);
      MODE_BREATHE: w_next = (pwm_cnt < w_level);
      default:      w_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= w_next;
  end

endmodule

`default_nettype wire

// File: rtl/led_pwm_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_pwm_multi                                              |
// | Description : NCH-channel LED driver on a shared prescaled PWM timebase  |
// |               with OFF/ON/PWM/BLINK/BREATHE modes. Config writes land in |
// |               a single pending slot and are committed at the PWM period  |
// |               boundary so a channel never changes mid-period.            |
// |   CLK         clock                                                      |
// |   RST_X       asynchronous reset, active-low                             |
// |   cfg         config write port (slave side of led_pwm_multi_if)         |
// |   LED         registered LED drive, 1 = on                               |
// |   period_end  1-cycle pulse following the last tick of each PWM period   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module led_pwm_multi
  import led_pwm_multi_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int PWM_W     = 8,
  parameter int STEP      = 10,
  parameter int BLINK_LEN = 8'h4f
) (
  input  logic             CLK,
  input  logic             RST_X,
  led_pwm_multi_if.slave   cfg,
  output logic [NCH-1:0]   LED,
  output logic             period_end
);

  localparam int CH_W  = (NCH > 1)       ? $clog2(NCH)       : 1;
  localparam int PRE_W = (STEP > 1)      ? $clog2(STEP)      : 1;
  localparam int BL_W  = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_LEN - 1);
  localparam logic [PWM_W-1:0] PWM_MAX  = {PWM_W{1'b1}};

  // ---------------- timebase ----------------
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             r_period_end;
  logic             w_tick;
  logic             w_bound;

  assign w_tick  = (r_pre_cnt == PRE_LAST);
  assign w_bound = w_tick && (r_pwm_cnt == PWM_MAX);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_pre_cnt    <= '0;
      r_pwm_cnt    <= '0;
      r_period_end <= 1'b0;
    end else begin
      r_pre_cnt    <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_period_end <= w_bound;
    end
  end

  assign period_end = r_period_end;

  // ---------------- blink phase ----------------
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_ph;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_bound) begin
      if (r_blink_cnt == BL_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- breathe ramp ----------------
  // Triangle 0..max..0; the turning step moves away from the end point
  // immediately, so each extreme appears for exactly one period.
  logic [PWM_W-1:0] r_ramp;
  ramp_dir_e        r_dir;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_ramp <= '0;
      r_dir  <= RAMP_UP;
    end else if (w_bound) begin
      if (r_dir == RAMP_UP) begin
        if (r_ramp == PWM_MAX) begin
          r_dir  <= RAMP_DOWN;
          r_ramp <= r_ramp - 1'b1;
        end else begin
          r_ramp <= r_ramp + 1'b1;
        end
      end else begin
        if (r_ramp == '0) begin
          r_dir  <= RAMP_UP;
          r_ramp <= r_ramp + 1'b1;
        end else begin
          r_ramp <= r_ramp - 1'b1;
        end
      end
    end
  end

  // ---------------- config slot ----------------
  logic             r_pending;
  logic [CH_W-1:0]  r_pend_ch;
  led_mode_e        r_pend_mode;
  logic [PWM_W-1:0] r_pend_duty;
  logic             r_err;
  logic             w_accept;
  logic             w_ch_bad;
  logic             w_bad;
  logic             w_commit;

  // Out-of-range channel numbers only exist when NCH is not a power of two.
  if (2**CH_W > NCH) begin : g_ch_range
    assign w_ch_bad = (cfg.ch > CH_W'(NCH - 1));
  end else begin : g_ch_full
    assign w_ch_bad = 1'b0;
  end

  assign cfg.ready = ~r_pending;
  assign cfg.err   = r_err;
  assign w_accept  = cfg.valid & ~r_pending;
  assign w_bad     = w_ch_bad | ~mode_is_legal(cfg.mode);
  assign w_commit  = w_bound & r_pending;

  // Rejected writes complete the handshake but never occupy the slot.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_pending   <= 1'b0;
      r_pend_ch   <= '0;
      r_pend_mode <= MODE_OFF;
      r_pend_duty <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad;
      if (w_accept && !w_bad) begin
        r_pending   <= 1'b1;
        r_pend_ch   <= cfg.ch;
        r_pend_mode <= led_mode_e'(cfg.mode);
        r_pend_duty <= cfg.duty;
      end else if (w_commit) begin
        r_pending   <= 1'b0;
      end
    end
  end

  // ---------------- channels ----------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_pwm_ch #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RST_X),
      .commit   (w_commit && (r_pend_ch == CH_W'(i))),
      .new_mode (r_pend_mode),
      .new_duty (r_pend_duty),
      .pwm_cnt  (r_pwm_cnt),
      .blink_ph (r_blink_ph),
      .ramp     (r_ramp),
      .led      (LED[i])
    );
  end

endmodule

`default_nettype wire
